// File: rtl/dmem_arbiter_if.sv
// Requester channel of the data-memory arbiter: one instance per master.
// The master modport belongs to the requester, the slave modport to the arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory (IDLE/ISSUE/WAIT/DONE).
// Optional grant/conflict counters are compiled in when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  output logic           mem_ce,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]    stat_m0,
  output logic [15:0]    stat_m1,
  output logic [15:0]    stat_conflict
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q;
  logic [2:0]    cnt_q;
  logic          win_q;
  logic          last_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          ce_q;
  logic          mwe_q;
  logic          gnt0_q, gnt1_q;
  logic          ack0_q, ack1_q;
  logic [DW-1:0] rd0_q, rd1_q;

  logic          any_req;
  logic          both_req;
  logic          win_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  assign any_req  = m0.req | m1.req;
  assign both_req = m0.req & m1.req;

  // win=1 selects m1; last_q=1 means m1 was served last
  always_comb begin
    win_d = ~m0.req;
    if (both_req) begin
      win_d = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
    end
    sel_we_d    = win_d ? m1.we    : m0.we;
    sel_addr_d  = win_d ? m1.addr  : m0.addr;
    sel_wdata_d = win_d ? m1.wdata : m0.wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ce_q    <= 1'b0;
      mwe_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q   <= win_d;
            we_q    <= sel_we_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            ce_q    <= 1'b1;
            mwe_q   <= sel_we_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          ce_q  <= 1'b0;
          mwe_q <= 1'b0;
          if (we_q || MEM_LAT == 0) begin
            if (!we_q) begin
              if (win_q) rd1_q <= mem_rdata;
              else       rd0_q <= mem_rdata;
            end
            ack0_q  <= ~win_q;
            ack1_q  <= win_q;
            state_q <= DONE;
          end else begin
            cnt_q   <= 3'(MEM_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            if (win_q) rd1_q <= mem_rdata;
            else       rd0_q <= mem_rdata;
            ack0_q  <= ~win_q;
            ack1_q  <= win_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ce    = ce_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0.gnt    = gnt0_q;
  assign m1.gnt    = gnt1_q;
  assign m0.ack    = ack0_q;
  assign m1.ack    = ack1_q;
  assign m0.rdata  = rd0_q;
  assign m1.rdata  = rd1_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_m0_q, stat_m1_q, stat_conflict_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_m0_q       <= '0;
      stat_m1_q       <= '0;
      stat_conflict_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      if (win_d) stat_m1_q <= sat_inc(stat_m1_q);
      else       stat_m0_q <= sat_inc(stat_m0_q);
      if (both_req) stat_conflict_q <= sat_inc(stat_conflict_q);
    end
  end

  assign stat_m0       = stat_m0_q;
  assign stat_m1       = stat_m1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four configurations (LAT/PRIO = 1/RR, 0/RR, 3/RR, 1/FIXED),
// a transaction-level reference model per configuration and directed scenarios.
module tb_dmem_arbiter;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   nvec = 0;
  int   nfail = 0;

  logic        req_a  [NC][2];
  logic        we_a   [NC][2];
  logic [31:0] addr_a [NC][2];
  logic [31:0] wd_a   [NC][2];
  logic        gnt_a  [NC][2];
  logic        ack_a  [NC][2];
  logic [31:0] rd_a   [NC][2];
  logic        ce_a   [NC];
  logic        mwe_a  [NC];
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] st_a   [NC][3];
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int LAT  = (g == 1) ? 0 : (g == 2) ? 3 : 1;
    localparam int PRIO = (g == 3) ? 1 : 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) p0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) p1 ();
    logic        ce, mwe;
    logic [31:0] maddr, mwd, mrdata, rd_now;
    logic [31:0] pipe [4];
    logic [31:0] dm [256];

    assign p0.req   = req_a[g][0];
    assign p0.we    = we_a[g][0];
    assign p0.addr  = addr_a[g][0];
    assign p0.wdata = wd_a[g][0];
    assign p1.req   = req_a[g][1];
    assign p1.we    = we_a[g][1];
    assign p1.addr  = addr_a[g][1];
    assign p1.wdata = wd_a[g][1];
    assign gnt_a[g][0] = p0.gnt;
    assign gnt_a[g][1] = p1.gnt;
    assign ack_a[g][0] = p0.ack;
    assign ack_a[g][1] = p1.ack;
    assign rd_a[g][0]  = p0.rdata;
    assign rd_a[g][1]  = p1.rdata;
    assign ce_a[g]     = ce;
    assign mwe_a[g]    = mwe;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .PRIO_MODE(PRIO)) u_dut (
      .clk(clk), .rst(rst_n), .m0(p0), .m1(p1),
      .mem_ce(ce), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwd), .mem_rdata(mrdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_m0(st_a[g][0]), .stat_m1(st_a[g][1]), .stat_conflict(st_a[g][2])
`endif
    );

    // Memory seen by the DUT: data appears LAT cycles after the enable cycle
    initial for (int i = 0; i < 256; i++) dm[i] = 32'h0;
    always @* rd_now = (ce && !mwe) ? dm[maddr[9:2]] : 32'h0;
    always @(posedge clk) begin
      if (ce && mwe) dm[maddr[9:2]] <= mwd;
      pipe[0] <= rd_now;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mrdata = (LAT == 0) ? rd_now : pipe[(LAT == 0) ? 0 : LAT - 1];

    // Transaction model: k counts cycles since the arbitration edge, dur is the ack cycle
    bit          busy, twe;
    int          k, dur, win, lastg;
    logic [31:0] tad, twd;
    logic [31:0] mrd [2];
    logic [31:0] mm [256];
    initial for (int i = 0; i < 256; i++) mm[i] = 32'h0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy = 0; twe = 0; k = 0; dur = 0; win = 0; lastg = 1;
        tad = 0; twd = 0; mrd[0] = 0; mrd[1] = 0;
      end else if (busy) begin
        if (k == 1 && twe) mm[tad[9:2]] = twd;
        if (k == dur) begin
          busy = 0;
          lastg = win;
        end else begin
          k++;
          if (k == dur && !twe) mrd[win] = mm[tad[9:2]];
        end
      end else if (req_a[g][0] || req_a[g][1]) begin
        if (req_a[g][0] && req_a[g][1]) win = (PRIO == 1) ? 0 : 1 - lastg;
        else win = req_a[g][0] ? 0 : 1;
        busy = 1; k = 1;
        twe = we_a[g][win]; tad = addr_a[g][win]; twd = wd_a[g][win];
        dur = twe ? 2 : 2 + LAT;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("c%0d gnt0", g), 64'(gnt_a[g][0]), 64'(busy && win == 0));
        chk($sformatf("c%0d gnt1", g), 64'(gnt_a[g][1]), 64'(busy && win == 1));
        chk($sformatf("c%0d ack0", g), 64'(ack_a[g][0]), 64'(busy && k == dur && win == 0));
        chk($sformatf("c%0d ack1", g), 64'(ack_a[g][1]), 64'(busy && k == dur && win == 1));
        chk($sformatf("c%0d rdata0", g), 64'(rd_a[g][0]), 64'(mrd[0]));
        chk($sformatf("c%0d rdata1", g), 64'(rd_a[g][1]), 64'(mrd[1]));
        chk($sformatf("c%0d mem_ce", g), 64'(ce), 64'(busy && k == 1));
        chk($sformatf("c%0d mem_we", g), 64'(mwe), 64'(busy && k == 1 && twe));
        chk($sformatf("c%0d mem_addr", g), 64'(maddr), 64'(tad));
        chk($sformatf("c%0d mem_wdata", g), 64'(mwd), 64'(twd));
      end
    end
  end

  // Starts in the cycle after a posedge with the DUT idle; lat is the ack cycle index
  task automatic txn(input int c, input int m, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int drop_at,
                     output int lat, output logic ce1, output logic we1);
    lat = -1; ce1 = 1'b0; we1 = 1'b0;
    @(posedge clk); #1;
    req_a[c][m] = 1'b1; we_a[c][m] = w; addr_a[c][m] = a; wd_a[c][m] = d;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 1) begin ce1 = ce_a[c]; we1 = mwe_a[c]; end
      if (j == drop_at) req_a[c][m] = 1'b0;
      if (ack_a[c][m]) begin lat = j; break; end
    end
    req_a[c][m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nack;
    logic ce1, we1;
    int o0[$];
    int o3[$];
    for (int c = 0; c < NC; c++) begin
      for (int m = 0; m < 2; m++) begin
        req_a[c][m] = 0; we_a[c][m] = 0; addr_a[c][m] = 0; wd_a[c][m] = 0;
      end
    end
    #1 rst_n = 1'b0;
    // Both masters request writes from reset on the RR and fixed-priority instances
    for (int c = 0; c < NC; c += 3) begin
      req_a[c][0] = 1; we_a[c][0] = 1; addr_a[c][0] = 32'h40; wd_a[c][0] = 32'hA0A0A0A0;
      req_a[c][1] = 1; we_a[c][1] = 1; addr_a[c][1] = 32'h44; wd_a[c][1] = 32'hB1B1B1B1;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset ack0", 64'(ack_a[0][0]), 64'd0);
    chk("reset mem_addr", 64'(g_cfg[0].maddr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int j = 0; j < 40 && o0.size() < 4; j++) begin
      @(negedge clk);
      if (ack_a[0][0]) o0.push_back(0);
      if (ack_a[0][1]) o0.push_back(1);
      if (ack_a[3][0]) o3.push_back(0);
      if (ack_a[3][1]) o3.push_back(1);
    end
    for (int m = 0; m < 2; m++) begin req_a[0][m] = 0; req_a[3][m] = 0; end
    chk("rr ack count", 64'(o0.size()), 64'd4);
    chk("fixed ack count", 64'(o3.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr order %0d", i), 64'((i < o0.size()) ? o0[i] : 9), 64'(i % 2));
      chk($sformatf("fixed order %0d", i), 64'((i < o3.size()) ? o3[i] : 9), 64'd0);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stat_m0", 64'(st_a[0][0]), 64'd2);
    chk("stat_m1", 64'(st_a[0][1]), 64'd2);
    chk("stat_conflict", 64'(st_a[0][2]), 64'd4);
`endif

    txn(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, -1, lat, ce1, we1);
    chk("wr lat", 64'(lat), 64'd2);
    chk("wr mem_ce c1", 64'(ce1), 64'd1);
    chk("wr mem_we c1", 64'(we1), 64'd1);

    txn(0, 1, 1'b0, 32'h10, 32'h0, -1, lat, ce1, we1);
    chk("rd lat1", 64'(lat), 64'd3);
    chk("m1 rdata", 64'(rd_a[0][1]), 64'hDEADBEEF);
    chk("m0 rdata kept", 64'(rd_a[0][0]), 64'd0);

    txn(0, 0, 1'b0, 32'h10, 32'h0, 1, lat, ce1, we1);
    chk("early drop lat", 64'(lat), 64'd3);
    chk("early drop rdata", 64'(rd_a[0][0]), 64'hDEADBEEF);

    txn(1, 0, 1'b1, 32'h20, 32'h12345678, -1, lat, ce1, we1);
    chk("lat0 wr lat", 64'(lat), 64'd2);
    txn(1, 0, 1'b0, 32'h20, 32'h0, -1, lat, ce1, we1);
    chk("lat0 rd lat", 64'(lat), 64'd2);
    chk("lat0 rdata", 64'(rd_a[1][0]), 64'h12345678);

    txn(2, 0, 1'b1, 32'h20, 32'hCAFEF00D, -1, lat, ce1, we1);
    chk("lat3 wr lat", 64'(lat), 64'd2);
    txn(2, 1, 1'b0, 32'h20, 32'h0, -1, lat, ce1, we1);
    chk("lat3 rd lat", 64'(lat), 64'd5);
    chk("lat3 rdata", 64'(rd_a[2][1]), 64'hCAFEF00D);

    // Reset while a read sits in WAIT
    @(posedge clk); #1;
    req_a[2][0] = 1; we_a[2][0] = 0; addr_a[2][0] = 32'h20;
    for (int j = 0; j < 4; j++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_a[2][0] = 0;
    #1;
    chk("rst gnt0", 64'(gnt_a[2][0]), 64'd0);
    chk("rst rdata1", 64'(rd_a[2][1]), 64'd0);
    chk("rst mem_addr", 64'(g_cfg[2].maddr), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    nack = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (ack_a[2][0] || ack_a[2][1]) nack++;
    end
    chk("no ack after rst", 64'(nack), 64'd0);
    txn(2, 0, 1'b0, 32'h20, 32'h0, -1, lat, ce1, we1);
    chk("post-rst rd lat", 64'(lat), 64'd5);
    chk("post-rst rdata", 64'(rd_a[2][0]), 64'hCAFEF00D);

`ifdef DMEM_ARB_STATS_EN
    @(posedge clk); #1;
    force g_cfg[0].u_dut.stat_m0_q = 16'hFFFF;
    @(negedge clk);
    release g_cfg[0].u_dut.stat_m0_q;
    txn(0, 0, 1'b1, 32'h50, 32'h5, -1, lat, ce1, we1);
    chk("stat sat", 64'(st_a[0][0]), 64'hFFFF);
`endif

    @(posedge clk); @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
